// File: rtl/addsub_pkg.sv
// addsub_pkg: shared width constants and the 22-bit result record for the add/sub result stage
package addsub_pkg;
  localparam int DATA_W = 16;
  localparam int CNT_W_DEF = 8;
  typedef struct packed {
    logic mode;
    logic n;
    logic z;
    logic v;
    logic b;
    logic c;
    logic [DATA_W-1:0] sum;
  } addsub_result_t;
endpackage

// File: rtl/addsub_result_stage_if.sv
// addsub_result_stage_if: adder-side inputs, consumer handshake, result/flag outputs and overflow counter; slave = stage, master = driver
interface addsub_result_stage_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W = 8
);
  logic in_valid, in_ready, mode, cout;
  logic [DATA_W-1:0] a, b, sum;
  logic out_valid, out_ready, out_mode, out_c, out_b, out_v, out_z, out_n;
  logic [DATA_W-1:0] out_sum;
  logic clr_cnt;
  logic [CNT_W-1:0] ovf_cnt;
  modport slave (
    input in_valid, a, b, mode, sum, cout, out_ready, clr_cnt,
    output in_ready, out_valid, out_sum, out_mode, out_c, out_b, out_v, out_z, out_n, ovf_cnt
  );
  modport master (
    output in_valid, a, b, mode, sum, cout, out_ready, clr_cnt,
    input in_ready, out_valid, out_sum, out_mode, out_c, out_b, out_v, out_z, out_n, ovf_cnt
  );
endinterface

// File: rtl/addsub_skid2.sv
// addsub_skid2: 2-entry FIFO skid buffer of addsub_result_t (in_valid_i/in_ready_o/in_data_i -> out_valid_o/out_ready_i/out_data_o), async reset clears storage
module addsub_skid2
  import addsub_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  addsub_result_t in_data_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output addsub_result_t out_data_o
);
  addsub_result_t mem_q [2];
  logic [1:0] count_q, count_d;
  logic head_q, tail_q, push, pop;
  assign in_ready_o  = ~count_q[1];
  assign out_valid_o = |count_q;
  assign out_data_o  = mem_q[head_q];
  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;
  always_comb count_d = count_q + 2'(push) - 2'(pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      count_q  <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[tail_q] <= in_data_i;
        tail_q <= ~tail_q;
      end
      if (pop) head_q <= ~head_q;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/addsub_result_stage.sv
// addsub_result_stage: flags {C,B,V,Z,N} from adder outputs, 2-deep skid buffer to consumer, saturating delivered-overflow count (clk, rst, bus)
module addsub_result_stage #(
  parameter int DATA_W = addsub_pkg::DATA_W,
  parameter int CNT_W  = addsub_pkg::CNT_W_DEF
) (
  input logic clk,
  input logic rst,
  addsub_result_stage_if.slave bus
);
  addsub_pkg::addsub_result_t in_rec, head_rec;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic bm, pop;
  always_comb begin
    bm          = bus.b[DATA_W-1] ^ bus.mode;
    in_rec.mode = bus.mode;
    in_rec.n    = bus.sum[DATA_W-1];
    in_rec.z    = bus.sum == '0;
    in_rec.v    = (bus.a[DATA_W-1] == bm) & (bus.sum[DATA_W-1] != bus.a[DATA_W-1]);
    in_rec.b    = bus.mode & ~bus.cout;
    in_rec.c    = bus.cout;
    in_rec.sum  = bus.sum;
  end
  addsub_skid2 u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (bus.in_valid),
    .in_ready_o (bus.in_ready),
    .in_data_i  (in_rec),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (head_rec)
  );
  assign pop = bus.out_valid & bus.out_ready;
  always_comb ovf_cnt_d = bus.clr_cnt ? '0 :
                          (pop & head_rec.v & ~&ovf_cnt_q) ? ovf_cnt_q + 1'b1 : ovf_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_cnt_q <= '0;
    else ovf_cnt_q <= ovf_cnt_d;
  end
  assign bus.out_sum  = head_rec.sum;
  assign bus.out_mode = head_rec.mode;
  assign bus.out_c    = head_rec.c;
  assign bus.out_b    = head_rec.b;
  assign bus.out_v    = head_rec.v;
  assign bus.out_z    = head_rec.z;
  assign bus.out_n    = head_rec.n;
  assign bus.ovf_cnt  = ovf_cnt_q;
endmodule

// File: tb/tb_addsub_result_stage.sv
// tb_addsub_result_stage: random and directed stimulus against an arithmetic FIFO reference model
module tb_addsub_result_stage;
  typedef struct {
    logic [15:0] sum;
    bit mode, n, z, v, b, c;
  } rec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  rec_t q[$];
  int cnt = 0;
  addsub_result_stage_if #(.DATA_W(16), .CNT_W(8)) bus ();
  addsub_result_stage dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic rec_t model(input logic [15:0] a, input logic [15:0] b, input bit mode);
    rec_t r;
    int u, s;
    u = mode ? int'(a) - int'(b) + 65536 : int'(a) + int'(b);
    s = mode ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
    r.sum  = u[15:0];
    r.c    = u > 65535;
    r.mode = mode;
    r.b    = mode && !r.c;
    r.v    = s > 32767 || s < -32768;
    r.z    = r.sum == 0;
    r.n    = r.sum[15];
    return r;
  endfunction
  task automatic check_outs();
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
    chk("ovf_cnt", 32'(bus.ovf_cnt), 32'(cnt));
    if (q.size() != 0)
      chk("head", {bus.out_mode, bus.out_n, bus.out_z, bus.out_v, bus.out_b, bus.out_c, bus.out_sum},
          {q[0].mode, q[0].n, q[0].z, q[0].v, q[0].b, q[0].c, q[0].sum});
  endtask
  task automatic step(input bit iv, input logic [15:0] a, input logic [15:0] b, input bit mode,
                      input bit ordy, input bit clr);
    rec_t r;
    bit push, pop;
    r = model(a, b, mode);
    bus.in_valid  = iv;
    bus.a         = a;
    bus.b         = b;
    bus.mode      = mode;
    bus.sum       = r.sum;
    bus.cout      = r.c;
    bus.out_ready = ordy;
    bus.clr_cnt   = clr;
    @(posedge clk);
    push = iv && q.size() < 2;
    pop  = ordy && q.size() > 0;
    if (pop && q[0].v && cnt < 255) cnt++;
    if (clr) cnt = 0;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(r);
    @(negedge clk);
    check_outs();
  endtask
  initial begin
    bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.mode = 0; bus.sum = 0; bus.cout = 0;
    bus.out_ready = 0; bus.clr_cnt = 0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_sum", 32'(bus.out_sum), 0);
    chk("rst_flags", {bus.out_mode, bus.out_n, bus.out_z, bus.out_v, bus.out_b, bus.out_c}, 0);
    chk("rst_ovf", 32'(bus.ovf_cnt), 0);
    rst = 0;
    step(1, 16'h7FFF, 16'h0001, 0, 0, 0);
    chk("add_ovf_flags", {bus.out_sum, bus.out_v, bus.out_n, bus.out_z, bus.out_c, bus.out_b},
        {16'h8000, 5'b11000});
    step(0, 0, 0, 0, 1, 0);
    chk("add_ovf_cnt", 32'(bus.ovf_cnt), 1);
    step(1, 16'h0005, 16'h0005, 1, 0, 0);
    chk("sub_zero_flags", {bus.out_sum, bus.out_z, bus.out_c, bus.out_b, bus.out_v, bus.out_n, bus.out_mode},
        {16'h0000, 6'b110001});
    step(0, 0, 0, 0, 1, 0);
    step(1, 16'h8000, 16'h0001, 1, 0, 0);
    chk("sub_ovf_flags", {bus.out_sum, bus.out_v, bus.out_n, bus.out_b}, {16'h7FFF, 3'b100});
    step(0, 0, 0, 0, 1, 0);
    step(1, 16'h0001, 16'h0002, 1, 0, 0);
    chk("sub_borrow_flags", {bus.out_sum, bus.out_b, bus.out_n, bus.out_v}, {16'hFFFF, 3'b110});
    step(0, 0, 0, 0, 1, 0);
    step(1, 16'h1111, 16'h0001, 0, 0, 0);
    chk("bp_ready_1", 32'(bus.in_ready), 1);
    step(1, 16'h2222, 16'h0002, 0, 0, 0);
    chk("bp_ready_2", 32'(bus.in_ready), 0);
    step(1, 16'h3333, 16'h0003, 0, 0, 0);
    chk("bp_held_head", 32'(bus.out_sum), 32'h1112);
    step(1, 16'h3333, 16'h0003, 0, 1, 0);
    chk("bp_second", 32'(bus.out_sum), 32'h2224);
    step(1, 16'h3333, 16'h0003, 0, 1, 0);
    chk("bp_third", 32'(bus.out_sum), 32'h3336);
    step(0, 0, 0, 0, 1, 0);
    chk("bp_drained", 32'(bus.out_valid), 0);
    for (int i = 0; i < 300; i++) step(1, 16'h7FFF, 16'h0001, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0, 1, 0);
    chk("sat_cnt", 32'(bus.ovf_cnt), 255);
    step(1, 16'h7FFF, 16'h0001, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    chk("clr_wins", 32'(bus.ovf_cnt), 0);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 16'({$urandom_range(0, 1), 15'h7FFF}) + 16'($urandom_range(0, 1)) : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 16'({$urandom_range(0, 1), 15'h7FFF}) + 16'($urandom_range(0, 1)) : 16'($urandom);
      step(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0), $urandom_range(0, 31) == 0);
    end
    step(1, 16'h4000, 16'h4000, 0, 0, 0);
    step(1, 16'h0100, 16'h0001, 1, 0, 0);
    chk("pre_rst_full", 32'(bus.in_ready), 0);
    #1 rst = 1;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_in_ready", 32'(bus.in_ready), 1);
    q.delete();
    cnt = 0;
    bus.in_valid = 0;
    @(negedge clk);
    rst = 0;
    step(0, 0, 0, 0, 0, 0);
    chk("post_rst_empty", 32'(bus.out_valid), 0);
    step(1, 16'h0003, 16'h0004, 0, 0, 0);
    chk("post_rst_fresh", 32'(bus.out_sum), 32'h0007);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
